// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and
// sizing helper for the bit counter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter must be able to hold 0..WIDTH.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from gate primitives.
//  x, y, bi : minuend bit, subtrahend bit, borrow-in
//  d        : difference bit  x ^ y ^ bi
//  bo       : borrow-out      (~x & y) | (~x & bi) | (y & bi)
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  wire nx;
  wire t_xy;
  wire t_xb;
  wire t_yb;

  not g_nx (nx, x);
  xor g_d  (d, x, y, bi);
  and g_a0 (t_xy, nx, y);
  and g_a1 (t_xb, nx, bi);
  and g_a2 (t_yb, y, bi);
  or  g_bo (bo, t_xy, t_xb, t_yb);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first,
// one bit per clock, with a start/done handshake.
//  clk, rst      : clock, synchronous active-high reset
//  start         : request, honoured in IDLE or DONE only
//  a, b, bin     : operands, latched on the accepting edge
//  busy          : subtraction in progress
//  done          : one-cycle pulse when diff/flags update
//  diff          : registered WIDTH-bit difference
//  bout          : unsigned borrow-out
//  zero          : diff == 0
//  ovf           : signed overflow
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned CW = cnt_w(WIDTH);

  state_e           state;
  state_e           state_n;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    count;

  logic             accept_c;
  logic             last_c;
  logic             d_c;
  logic             bo_c;
  logic [WIDTH-1:0] diff_c;

  // Single bit-slice shared by every cycle of the operation.
  full_subtractor u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (borrow),
    .d  (d_c),
    .bo (bo_c)
  );

  // Full result as it stands once the current bit is shifted in.
  assign diff_c = {d_c, res_sr};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and control decode.
  always_comb begin
    state_n  = state;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_n  = RUN;
        end
      end
      RUN: begin
        if (count == CW'(WIDTH - 1)) begin
          last_c  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_n  = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand shifting, borrow chain and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_c) begin
        a_sr   <= a;
        b_sr   <= b;
        borrow <= bin;
        // MSBs are shifted out during RUN, so keep them for the overflow flag.
        a_msb  <= a[WIDTH-1];
        b_msb  <= b[WIDTH-1];
        count  <= '0;
        busy   <= 1'b1;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        borrow <= bo_c;
        res_sr <= diff_c[WIDTH-1:1];
        count  <= count + CW'(1);
        if (last_c) begin
          diff <= diff_c;
          bout <= bo_c;
          zero <= (diff_c == '0);
          ovf  <= (a_msb != b_msb) && (d_c != a_msb);
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, bin8, start4, bin4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       busy8, done8, bout8, zero8, ovf8;
  logic       busy4, done4, bout4, zero4, ovf4;
  logic [7:0] diff8;
  logic [3:0] diff4;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  logic [10:0] prev8;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4), .ovf(ovf4)
  );

  // Reference: {ovf, zero, bout, diff[7:0]} from integer arithmetic.
  function automatic logic [10:0] model(input int w, input int ta, input int tb, input int tbin);
    int full, half, d, sa, sb, sd;
    logic [10:0] r;
    full = 1 << w;
    half = 1 << (w - 1);
    d  = ta - tb - tbin;
    sa = (ta >= half) ? ta - full : ta;
    sb = (tb >= half) ? tb - full : tb;
    sd = sa - sb - tbin;
    r = '0;
    r[7:0] = 8'(d & (full - 1));
    r[8]   = (d < 0);
    r[9]   = ((d & (full - 1)) == 0);
    r[10]  = (sd < -half) || (sd > half - 1);
    return r;
  endfunction

  function automatic logic [10:0] obs8();
    return {ovf8, zero8, bout8, diff8};
  endfunction

  // One 8-bit operation; inject > 0 re-pulses start (with a=FF) at that RUN cycle.
  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         input int inject);
    logic [10:0] exp;
    int k;
    bit got;
    exp = model(8, int'(ta), int'(tb), int'(tbin));
    @(negedge clk);
    start8 = 1'b1; a8 = ta; b8 = tb; bin8 = tbin;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    k = 0; got = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (inject > 0 && k == inject) begin start8 = 1'b1; a8 = 8'hFF; end
      if (inject > 0 && k == inject + 1) start8 = 1'b0;
      if (done8 === 1'b1) got = 1;
      else begin
        n_vec++;
        if (busy8 !== 1'b1 || obs8() !== prev8) begin
          n_fail++;
          $display("FAIL hold k=%0d: busy=%b out=%h, required busy=1 out=%h", k, busy8, obs8(), prev8);
        end
      end
    end
    n_vec++;
    if (!got || k != 8) begin
      n_fail++;
      $display("FAIL latency a=%h b=%h: done after %0d edges (seen=%0d), required 8", ta, tb, k, got);
    end
    n_vec++;
    if (diff8 !== exp[7:0]) begin
      n_fail++;
      $display("FAIL diff a=%h b=%h bin=%b: got %h, required %h", ta, tb, tbin, diff8, exp[7:0]);
    end
    n_vec++;
    if ({ovf8, zero8, bout8, busy8} !== {exp[10:8], 1'b0}) begin
      n_fail++;
      $display("FAIL flags a=%h b=%h bin=%b: ovf/zero/bout/busy=%b%b%b%b, required %b0",
               ta, tb, tbin, ovf8, zero8, bout8, busy8, exp[10:8]);
    end
    prev8 = exp;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if (done8 !== 1'b0 || obs8() !== prev8) begin
        n_fail++;
        $display("FAIL post-done %0d: done=%b out=%h, required done=0 out=%h", i, done8, obs8(), prev8);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy8, done8, diff8, bout8, zero8, ovf8} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset8: busy/done/diff/bout/zero/ovf=%b/%b/%h/%b/%b/%b, required all 0",
               busy8, done8, diff8, bout8, zero8, ovf8);
    end
    n_vec++;
    if ({busy4, done4, diff4, bout4, zero4, ovf4} !== 8'h0) begin
      n_fail++;
      $display("FAIL reset4: busy/done/diff/bout/zero/ovf=%b/%b/%h/%b/%b/%b, required all 0",
               busy4, done4, diff4, bout4, zero4, ovf4);
    end
    rst = 1'b0;
    prev8 = '0;
  endtask

  task automatic test_directed();
    run_op8(8'h05, 8'h03, 1'b0, 0);
    run_op8(8'h00, 8'h01, 1'b0, 0);
    run_op8(8'h80, 8'h01, 1'b0, 0);
    run_op8(8'h10, 8'h0F, 1'b1, 0);
    run_op8(8'h2A, 8'h2A, 1'b1, 0);
    run_op8(8'h80, 8'h00, 1'b1, 0);
    run_op8(8'h7F, 8'hFF, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), 0);
  endtask

  task automatic test_ignore_start();
    run_op8(8'h05, 8'h03, 1'b0, 3);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h37; b8 = 8'h12; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({busy8, done8, diff8, bout8, zero8, ovf8} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset-mid: busy/done/diff/bout/zero/ovf=%b/%b/%h/%b/%b/%b, required all 0",
               busy8, done8, diff8, bout8, zero8, ovf8);
    end
    prev8 = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset-abort cyc %0d: done=%b busy=%b, required 0/0", i, done8, busy8);
      end
    end
    run_op8(8'h05, 8'h03, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [10:0] q[$];
    logic [10:0] exp;
    bit exp_done;
    for (int c = 0; c < 36; c++) begin
      start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      if (c % 9 == 0) q.push_back(model(8, int'(a8), int'(b8), int'(bin8)));
      @(negedge clk);
      exp_done = (c % 9 == 8);
      n_vec++;
      if (done8 !== exp_done) begin
        n_fail++;
        $display("FAIL b2b done c=%0d: got %b, required %b", c, done8, exp_done);
      end
      if (exp_done && q.size() > 0) begin
        exp = q.pop_front();
        n_vec++;
        if (obs8() !== exp) begin
          n_fail++;
          $display("FAIL b2b result c=%0d: ovf/zero/bout/diff=%h, required %h", c, obs8(), exp);
        end
        prev8 = exp;
      end
    end
    start8 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_width4();
    logic [10:0] exp;
    logic [3:0] ta, tb;
    logic tbin;
    int k;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin ta = 4'h5; tb = 4'h3; tbin = 1'b0; end
      else begin ta = 4'($urandom); tb = 4'($urandom); tbin = 1'($urandom); end
      exp = model(4, int'(ta), int'(tb), int'(tbin));
      @(negedge clk);
      start4 = 1'b1; a4 = ta; b4 = tb; bin4 = tbin;
      @(negedge clk);
      start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
      k = 0;
      while (done4 !== 1'b1 && k < 12) begin
        @(negedge clk);
        k++;
      end
      n_vec++;
      if (k != 4) begin
        n_fail++;
        $display("FAIL w4 latency a=%h b=%h: done after %0d edges, required 4", ta, tb, k);
      end
      n_vec++;
      if ({ovf4, zero4, bout4, diff4} !== {exp[10:8], exp[3:0]}) begin
        n_fail++;
        $display("FAIL w4 result a=%h b=%h bin=%b: ovf/zero/bout/diff=%b%b%b/%h, required %b/%h",
                 ta, tb, tbin, ovf4, zero4, bout4, diff4, exp[10:8], exp[3:0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    prev8 = '0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_width4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
